awgn: RTL and testbench
=======================

# awgn

Additive white Gaussian noise channel model for the digital-communications datapath. Each cycle it takes a signed 8-bit real sample, adds a pseudo-random approximately-Gaussian noise sample, and produces a saturated noisy real output. It also produces an independent noise-only imaginary output and a flag that marks real-path saturation. It sits between the transmitter and receiver, and its noise output is also tapped for per-bit corruption in the top level.

## Interface
- `SEED_RE`, default 32'hACE1_2468: reset seed of the real-path LFSR; must be nonzero.
- `SEED_IM`, default 32'h1357_BDF9: reset seed of the imaginary-path LFSR; must be nonzero.
- `NOISE_SHIFT`, default 1: arithmetic right shift applied to the raw noise sum; this sets sigma.
- `clk`  in  1  Rising-edge clock.
- `reset`  in  1  Asynchronous, active-high reset.
- `enable`  in  1  1 = advance the LFSRs and the pipeline; 0 = freeze all state.
- `data_in`  in  8  Signed two's-complement real input sample.
- `bypass`  in  1  1 = noise forced to 0 at the adder (LFSRs still advance); 0 = noise applied.
- `busy`  out  1  High during post-reset warm-up.
- `Y_out_real`  out  8  Signed, saturated `data_in + noise_re`.
- `Y_out_imag`  out  8  Signed, saturated `noise_im`. There is no imaginary input.
- `sum_real_n_truncation`  out  1  High when the current `Y_out_real` was saturated.

## Operation
- **LFSR:** two independent 32-bit Fibonacci LFSRs, re and im.
  - Step rule: `fb = s[31]^s[21]^s[1]^s[0]`; `s <= {s[30:0], fb}`.
  - 16 steps per enabled cycle, unrolled combinationally.
- **Raw noise per path:** taken from the post-advance state.
  - Four unsigned nibbles: `s[3:0]`, `s[11:8]`, `s[19:16]`, `s[27:24]`.
  - `u = sum of the four nibbles`, range 0..60.
  - `raw = u - 30`, signed range -30..+30.
- **Scaled noise:** `n = raw >>> NOISE_SHIFT`. With the default this is -15..+15.
- **Bypass:** if `bypass`=1, `n` is replaced by 0 at the adder input.
- **Real path:**
  - 9-bit signed sum `t = sext(data_in) + sext(n_re)`.
  - `Y_out_real = clamp(t, -128, 127)`.
  - `sum_real_n_truncation = (t > 127) || (t < -128)`.
- **Imag path:** `Y_out_imag = clamp(n_im, -128, 127)`. It cannot saturate at the default shift. It has no flag.
- **Warm-up:** a 3-bit counter runs after reset release.
  - `busy`=1 until 4 enabled cycles have elapsed.
  - While `busy`=1, the LFSRs advance but all outputs are held at 0.

## Timing
- **Reset (asynchronous, immediate):**
  - LFSRs load `SEED_RE`/`SEED_IM`.
  - Pipeline registers, `Y_out_real`, `Y_out_imag` and `sum_real_n_truncation` go to 0.
  - `busy` goes to 1 and the warm-up counter goes to 0.
- **Pipeline:** 2 stages.
  - Stage 1 registers `data_in`, `n_re` and `n_im`.
  - Stage 2 registers the saturated outputs and the flag.
  - `data_in` sampled at edge k appears on `Y_out_real` after edge k+1, i.e. latency 2 clocks.
- **Flag alignment:** `sum_real_n_truncation` is registered in the same stage as `Y_out_real` and is always aligned with it.
- **Busy:** `busy` falls on the 4th enabled rising edge after reset deassertion. The first valid output follows on that same edge.
- **enable=0:** LFSRs, pipeline, counter and outputs all hold their values. Resuming continues the exact same noise sequence.
- **Reset mid-stream:** everything is cleared at once. The noise sequence restarts from the seeds, so it is reproducible.
- **No handshake:** the block is free-running; one sample per enabled cycle.

## Test plan
- **Reset:** assert `reset` for 2 cycles, then release with `enable`=1.
  - All outputs are 0 during reset.
  - `busy`=1 for exactly 4 edges after release, then 0.
- **Bypass pass-through:** `bypass`=1, `data_in`=8'h55 held.
  - `Y_out_real`=8'h55 two cycles after it is applied.
  - `Y_out_imag`=0 and the flag is 0.
- **Positive saturation:** `bypass`=0, `data_in`=8'h7F for 256 cycles.
  - `Y_out_real` stays within 8'h70..8'h7F.
  - The flag is 1 exactly on cycles where the aligned `n_re` > 0.
  - The flag is never 1 when `Y_out_real` < 8'h7F.
- **Negative saturation:** `data_in`=8'h80.
  - `Y_out_real` stays within 8'h80..8'h8F.
  - The flag is 1 exactly when `n_re` < 0.
- **Statistics:** `data_in`=0 for 4096 samples.
  - All `Y_out_real` and `Y_out_imag` values lie in -15..+15.
  - Sample means lie within ±1.
  - The real and imag sequences differ.
- **Freeze and reproducibility:**
  - Drop `enable` for 10 cycles: outputs hold, and the resumed sequence is identical to an uninterrupted run.
  - Reset mid-stream: the first 8 post-warm-up samples match those after the first reset.

Source files
------------

// File: rtl/awgn.sv
// AWGN channel model: two 32-bit LFSRs produce sum-of-nibbles noise that is added
// to the real sample (saturated) and emitted alone on the imaginary output.
module awgn #(
    parameter logic [31:0] SEED_RE     = 32'hACE1_2468,
    parameter logic [31:0] SEED_IM     = 32'h1357_BDF9,
    parameter int          NOISE_SHIFT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic signed [7:0] data_in,
    input  logic              bypass,
    output logic              busy,
    output logic signed [7:0] Y_out_real,
    output logic signed [7:0] Y_out_imag,
    output logic              sum_real_n_truncation
);

    localparam int STEPS = 16;

    logic [31:0]       lfsr_re_reg;
    logic [31:0]       lfsr_im_reg;
    logic [31:0]       chain_re [0:STEPS];
    logic [31:0]       chain_im [0:STEPS];

    logic signed [6:0] noise_re_next;
    logic signed [6:0] noise_im_next;

    logic signed [7:0] data_s1_reg;
    logic signed [6:0] n_re_s1_reg;
    logic signed [6:0] n_im_s1_reg;

    logic signed [8:0] sum_re_next;
    logic signed [7:0] y_re_next;
    logic signed [7:0] y_im_next;
    logic              trunc_next;

    logic signed [7:0] y_re_reg;
    logic signed [7:0] y_im_reg;
    logic              trunc_reg;

    logic [2:0]        warm_cnt_reg;
    logic              busy_reg;
    logic              out_valid;

    // Sum of four nibbles is roughly Gaussian around 30; centre it, then scale.
    function automatic logic signed [6:0] nibble_noise(input logic [31:0] s);
        logic [5:0]        u;
        logic signed [6:0] raw;
        u   = {2'b00, s[3:0]} + {2'b00, s[11:8]} + {2'b00, s[19:16]} + {2'b00, s[27:24]};
        raw = $signed({1'b0, u}) - 7'sd30;
        return raw >>> NOISE_SHIFT;
    endfunction

    assign chain_re[0] = lfsr_re_reg;
    assign chain_im[0] = lfsr_im_reg;

    // Sixteen Fibonacci steps per enabled cycle, fully unrolled.
    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
            assign chain_re[gi+1] = {chain_re[gi][30:0],
                                     chain_re[gi][31] ^ chain_re[gi][21] ^ chain_re[gi][1] ^ chain_re[gi][0]};
            assign chain_im[gi+1] = {chain_im[gi][30:0],
                                     chain_im[gi][31] ^ chain_im[gi][21] ^ chain_im[gi][1] ^ chain_im[gi][0]};
        end
    endgenerate

    assign noise_re_next = bypass ? 7'sd0 : nibble_noise(chain_re[STEPS]);
    assign noise_im_next = bypass ? 7'sd0 : nibble_noise(chain_im[STEPS]);

    always_comb begin
        sum_re_next = {data_s1_reg[7], data_s1_reg} + {{2{n_re_s1_reg[6]}}, n_re_s1_reg};
        trunc_next  = sum_re_next[8] ^ sum_re_next[7];
        if (trunc_next) begin
            y_re_next = sum_re_next[8] ? 8'sh80 : 8'sh7F;
        end else begin
            y_re_next = sum_re_next[7:0];
        end
        // Noise never exceeds 7 bits, so sign extension is already the clamp.
        y_im_next = {n_im_s1_reg[6], n_im_s1_reg};
    end

    // The fourth enabled edge both clears busy and loads the first real output.
    assign out_valid = !busy_reg || (warm_cnt_reg == 3'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_re_reg  <= SEED_RE;
            lfsr_im_reg  <= SEED_IM;
            data_s1_reg  <= '0;
            n_re_s1_reg  <= '0;
            n_im_s1_reg  <= '0;
            y_re_reg     <= '0;
            y_im_reg     <= '0;
            trunc_reg    <= 1'b0;
            warm_cnt_reg <= 3'd0;
            busy_reg     <= 1'b1;
        end else if (enable) begin
            lfsr_re_reg <= chain_re[STEPS];
            lfsr_im_reg <= chain_im[STEPS];
            data_s1_reg <= data_in;
            n_re_s1_reg <= noise_re_next;
            n_im_s1_reg <= noise_im_next;
            if (busy_reg) begin
                warm_cnt_reg <= warm_cnt_reg + 3'd1;
                if (warm_cnt_reg == 3'd3) begin
                    busy_reg <= 1'b0;
                end
            end
            if (out_valid) begin
                y_re_reg  <= y_re_next;
                y_im_reg  <= y_im_next;
                trunc_reg <= trunc_next;
            end
        end
    end

    assign busy                  = busy_reg;
    assign Y_out_real            = y_re_reg;
    assign Y_out_imag            = y_im_reg;
    assign sum_real_n_truncation = trunc_reg;

endmodule

// File: tb/tb_awgn.sv
// Scoreboard bench for awgn: a reference noise model queues expected outputs at
// drive time; each scenario task pops and compares them as the DUT produces them.
module tb_awgn;

    localparam logic [31:0] SEED_RE     = 32'hACE1_2468;
    localparam logic [31:0] SEED_IM     = 32'h1357_BDF9;
    localparam int          NOISE_SHIFT = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       bypass = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       busy;
    logic [7:0] y_re;
    logic [7:0] y_im;
    logic       flag;

    always #5 clk = ~clk;

    awgn #(
        .SEED_RE(SEED_RE),
        .SEED_IM(SEED_IM),
        .NOISE_SHIFT(NOISE_SHIFT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .data_in(data_in),
        .bypass(bypass),
        .busy(busy),
        .Y_out_real(y_re),
        .Y_out_imag(y_im),
        .sum_real_n_truncation(flag)
    );

    typedef struct {
        logic [7:0] y_re;
        logic [7:0] y_im;
        logic       flag;
        logic       busy;
        int         n_re;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    exp_t        first_run[8];
    logic [31:0] m_re;
    logic [31:0] m_im;
    int          m_edges;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] step16(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 16; i++) r = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
        return r;
    endfunction

    function automatic int noise(input logic [31:0] s);
        int u;
        u = int'(s[3:0]) + int'(s[11:8]) + int'(s[19:16]) + int'(s[27:24]);
        return (u - 30) >>> NOISE_SHIFT;
    endfunction

    function automatic logic [7:0] clamp8(input int v);
        if (v > 127) return 8'h7F;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    task automatic model_reset();
        sb.delete();
        m_re      = SEED_RE;
        m_im      = SEED_IM;
        m_edges   = 0;
        cur.y_re  = 8'h00;
        cur.y_im  = 8'h00;
        cur.flag  = 1'b0;
        cur.busy  = 1'b1;
        cur.n_re  = 0;
    endtask

    // One enabled cycle: queue the expected result, clock, then pop what is due now.
    task automatic drive_cycle(input logic [7:0] d, input logic byp);
        exp_t e;
        int   nre;
        int   nim;
        int   t;
        data_in = d;
        bypass  = byp;
        enable  = 1'b1;
        m_re = step16(m_re);
        m_im = step16(m_im);
        nre  = byp ? 0 : noise(m_re);
        nim  = byp ? 0 : noise(m_im);
        t    = int'($signed(d)) + nre;
        e.y_re = clamp8(t);
        e.y_im = clamp8(nim);
        e.flag = (t > 127) || (t < -128);
        e.busy = 1'b0;
        e.n_re = nre;
        sb.push_back(e);
        @(posedge clk);
        #1;
        m_edges++;
        if (m_edges >= 2) e = sb.pop_front();
        if (m_edges >= 4) begin
            cur = e;
        end else begin
            cur.y_re = 8'h00;
            cur.y_im = 8'h00;
            cur.flag = 1'b0;
            cur.busy = 1'b1;
            cur.n_re = 0;
        end
    endtask

    task automatic freeze_cycle();
        enable  = 1'b0;
        data_in = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (y_re !== 8'h00) begin errors++; $display("FAIL reset_y_re: got %h expected 00", y_re); end
        checks++; if (y_im !== 8'h00) begin errors++; $display("FAIL reset_y_im: got %h expected 00", y_im); end
        checks++; if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b expected 0", flag); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(8'h00, 1'b0);
            checks++; if (busy !== cur.busy) begin errors++; $display("FAIL warmup_busy edge %0d: got %b expected %b", m_edges, busy, cur.busy); end
            checks++; if (y_re !== cur.y_re) begin errors++; $display("FAIL warmup_y_re edge %0d: got %h expected %h", m_edges, y_re, cur.y_re); end
            checks++; if (y_im !== cur.y_im) begin errors++; $display("FAIL warmup_y_im edge %0d: got %h expected %h", m_edges, y_im, cur.y_im); end
            if (m_edges >= 4 && m_edges < 12) first_run[m_edges-4] = cur;
        end
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 8; i++) begin
            drive_cycle(8'h55, 1'b1);
            checks++; if (y_re !== cur.y_re) begin errors++; $display("FAIL bypass_y_re cycle %0d: got %h expected %h", i, y_re, cur.y_re); end
            checks++; if (y_im !== cur.y_im) begin errors++; $display("FAIL bypass_y_im cycle %0d: got %h expected %h", i, y_im, cur.y_im); end
            checks++; if (flag !== cur.flag) begin errors++; $display("FAIL bypass_flag cycle %0d: got %b expected %b", i, flag, cur.flag); end
        end
        checks++; if (y_re !== 8'h55) begin errors++; $display("FAIL bypass_passthru: got %h expected 55", y_re); end
        checks++; if (y_im !== 8'h00) begin errors++; $display("FAIL bypass_imag_zero: got %h expected 00", y_im); end
        checks++; if (flag !== 1'b0) begin errors++; $display("FAIL bypass_flag_zero: got %b expected 0", flag); end
    endtask

    task automatic test_pos_sat();
        for (int i = 0; i < 256; i++) begin
            drive_cycle(8'h7F, 1'b0);
            checks++; if (y_re !== cur.y_re) begin errors++; $display("FAIL possat_y_re cycle %0d: got %h expected %h", i, y_re, cur.y_re); end
            checks++; if (flag !== cur.flag) begin errors++; $display("FAIL possat_flag cycle %0d: got %b expected %b (n_re %0d)", i, flag, cur.flag, cur.n_re); end
            if (i > 0) begin
                checks++; if (y_re < 8'h70 || y_re > 8'h7F) begin errors++; $display("FAIL possat_range cycle %0d: got %h expected 70..7f", i, y_re); end
                checks++; if (flag === 1'b1 && y_re !== 8'h7F) begin errors++; $display("FAIL possat_flag_unsat cycle %0d: got flag 1 with %h expected 7f", i, y_re); end
            end
        end
    endtask

    task automatic test_neg_sat();
        for (int i = 0; i < 256; i++) begin
            drive_cycle(8'h80, 1'b0);
            checks++; if (y_re !== cur.y_re) begin errors++; $display("FAIL negsat_y_re cycle %0d: got %h expected %h", i, y_re, cur.y_re); end
            checks++; if (flag !== cur.flag) begin errors++; $display("FAIL negsat_flag cycle %0d: got %b expected %b (n_re %0d)", i, flag, cur.flag, cur.n_re); end
            if (i > 0) begin
                checks++; if (y_re < 8'h80 || y_re > 8'h8F) begin errors++; $display("FAIL negsat_range cycle %0d: got %h expected 80..8f", i, y_re); end
            end
        end
    endtask

    task automatic test_stats();
        int sum_re = 0;
        int sum_im = 0;
        int n_diff = 0;
        int n = 0;
        for (int i = 0; i < 4096; i++) begin
            drive_cycle(8'h00, 1'b0);
            checks++; if (y_re !== cur.y_re) begin errors++; $display("FAIL stats_y_re cycle %0d: got %h expected %h", i, y_re, cur.y_re); end
            checks++; if (y_im !== cur.y_im) begin errors++; $display("FAIL stats_y_im cycle %0d: got %h expected %h", i, y_im, cur.y_im); end
            if (i > 0) begin
                checks++; if ($signed(y_re) < -15 || $signed(y_re) > 15) begin errors++; $display("FAIL stats_range_re cycle %0d: got %0d expected -15..15", i, $signed(y_re)); end
                checks++; if ($signed(y_im) < -15 || $signed(y_im) > 15) begin errors++; $display("FAIL stats_range_im cycle %0d: got %0d expected -15..15", i, $signed(y_im)); end
                sum_re += int'($signed(y_re));
                sum_im += int'($signed(y_im));
                if (y_re !== y_im) n_diff++;
                n++;
            end
        end
        checks++; if (sum_re > n || sum_re < -n) begin errors++; $display("FAIL stats_mean_re: got sum %0d over %0d expected |mean|<=1", sum_re, n); end
        checks++; if (sum_im > n || sum_im < -n) begin errors++; $display("FAIL stats_mean_im: got sum %0d over %0d expected |mean|<=1", sum_im, n); end
        checks++; if (n_diff == 0) begin errors++; $display("FAIL stats_re_im_differ: got %0d differing expected >0", n_diff); end
    endtask

    task automatic test_freeze();
        logic [7:0] d;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            drive_cycle(d, 1'b0);
            checks++; if (y_re !== cur.y_re) begin errors++; $display("FAIL freeze_pre_y_re cycle %0d: got %h expected %h", i, y_re, cur.y_re); end
        end
        for (int i = 0; i < 10; i++) begin
            freeze_cycle();
            checks++; if (y_re !== cur.y_re) begin errors++; $display("FAIL freeze_hold_y_re cycle %0d: got %h expected %h", i, y_re, cur.y_re); end
            checks++; if (y_im !== cur.y_im) begin errors++; $display("FAIL freeze_hold_y_im cycle %0d: got %h expected %h", i, y_im, cur.y_im); end
            checks++; if (flag !== cur.flag) begin errors++; $display("FAIL freeze_hold_flag cycle %0d: got %b expected %b", i, flag, cur.flag); end
        end
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            drive_cycle(d, 1'b0);
            checks++; if (y_re !== cur.y_re) begin errors++; $display("FAIL freeze_resume_y_re cycle %0d: got %h expected %h", i, y_re, cur.y_re); end
            checks++; if (y_im !== cur.y_im) begin errors++; $display("FAIL freeze_resume_y_im cycle %0d: got %h expected %h", i, y_im, cur.y_im); end
            checks++; if (flag !== cur.flag) begin errors++; $display("FAIL freeze_resume_flag cycle %0d: got %b expected %b", i, flag, cur.flag); end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) drive_cycle(8'h7F, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (y_re !== 8'h00) begin errors++; $display("FAIL midreset_y_re: got %h expected 00", y_re); end
        checks++; if (y_im !== 8'h00) begin errors++; $display("FAIL midreset_y_im: got %h expected 00", y_im); end
        checks++; if (flag !== 1'b0) begin errors++; $display("FAIL midreset_flag: got %b expected 0", flag); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy: got %b expected 1", busy); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_cycle(8'h00, 1'b0);
            checks++; if (busy !== cur.busy) begin errors++; $display("FAIL midreset_warmup_busy edge %0d: got %b expected %b", m_edges, busy, cur.busy); end
            if (m_edges >= 4 && m_edges < 12) begin
                checks++; if (y_re !== first_run[m_edges-4].y_re) begin errors++; $display("FAIL midreset_repro_re sample %0d: got %h expected %h", m_edges-4, y_re, first_run[m_edges-4].y_re); end
                checks++; if (y_im !== first_run[m_edges-4].y_im) begin errors++; $display("FAIL midreset_repro_im sample %0d: got %h expected %h", m_edges-4, y_im, first_run[m_edges-4].y_im); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_pos_sat();
        test_neg_sat();
        test_stats();
        test_freeze();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
